// File: rtl/ud_ld_counter_gen_if.sv
// Control/status bundle for the up/down loadable counter.
// The master drives the controls and the slave (the counter) returns count and status.
interface ud_ld_counter_gen_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              enable;
  logic              updown;
  logic              load;
  logic [WIDTH-1:0]  load_count;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  lower;
  logic [WIDTH-1:0]  upper;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  count_out;
  logic              done;
  logic              dir_out;
  logic              running;
  logic              cfg_err;

  modport master (
    output enable, updown, load, load_count, step, lower, upper, mode,
    input  count_out, done, dir_out, running, cfg_err
  );

  modport slave (
    input  enable, updown, load, load_count, step, lower, upper, mode,
    output count_out, done, dir_out, running, cfg_err
  );
endinterface

// File: rtl/ud_ld_counter_gen.sv
// Parametrised up/down loadable counter with programmable bounds, runtime step
// and wrap / saturate / one-shot / bounce terminal-count behaviour.
module ud_ld_counter_gen #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  ud_ld_counter_gen_if.slave  bus
);

  localparam int unsigned XW = WIDTH + 1;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_BOUNCE  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_count;
  logic             r_done;
  logic             r_dir;
  logic             r_run;

  logic [WIDTH-1:0] w_count_n;
  logic             w_done_n;
  logic             w_dir_n;
  logic             w_run_n;

  mode_e            w_mode;
  logic             w_cfg_err;
  logic             w_dir_eff;
  logic [XW-1:0]    w_step_x;
  logic [XW-1:0]    w_cnt_x;
  logic [XW-1:0]    w_lo_x;
  logic [XW-1:0]    w_up_x;
  logic [XW-1:0]    w_nxt_up;
  logic [XW-1:0]    w_nxt_dn;
  logic             w_up_over;
  logic             w_up_at;
  logic             w_dn_below;
  logic             w_dn_at;
  logic             w_hit;
  logic [WIDTH-1:0] w_bound;
  logic [WIDTH-1:0] w_stepped;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_mode    = mode_e'(bus.mode);
  assign w_cfg_err = (bus.lower > bus.upper);
  assign w_dir_eff = (w_mode == MODE_BOUNCE) ? r_dir : bus.updown;

  // Step arithmetic one bit wider so overflow and borrow are visible.
  assign w_step_x   = (bus.step == '0) ? XW'(1) : XW'(bus.step);
  assign w_cnt_x    = XW'(r_count);
  assign w_lo_x     = XW'(bus.lower);
  assign w_up_x     = XW'(bus.upper);
  assign w_nxt_up   = w_cnt_x + w_step_x;
  assign w_nxt_dn   = w_cnt_x - w_step_x;
  assign w_up_over  = (w_nxt_up > w_up_x);
  assign w_up_at    = (w_nxt_up == w_up_x);
  assign w_dn_below = w_nxt_dn[WIDTH] || (w_nxt_dn < w_lo_x);
  assign w_dn_at    = !w_nxt_dn[WIDTH] && (w_nxt_dn == w_lo_x);

  assign w_hit     = w_dir_eff ? (w_up_over || w_up_at) : (w_dn_below || w_dn_at);
  assign w_bound   = w_dir_eff ? bus.upper : bus.lower;
  assign w_stepped = w_dir_eff ? w_nxt_up[WIDTH-1:0] : w_nxt_dn[WIDTH-1:0];

  assign w_load_clamped = (bus.load_count < bus.lower) ? bus.lower :
                          (bus.load_count > bus.upper) ? bus.upper : bus.load_count;

  // Next-state selection: cfg_err hold > load > enabled step > hold.
  always_comb begin
    w_count_n = r_count;
    w_done_n  = 1'b0;
    w_dir_n   = r_dir;
    w_run_n   = r_run;
    if (!w_cfg_err) begin
      if (w_mode != MODE_BOUNCE) begin
        w_dir_n = bus.updown;
      end
      if (bus.load) begin
        w_count_n = w_load_clamped;
        w_run_n   = 1'b1;
        w_dir_n   = bus.updown;
      end else if (bus.enable && r_run) begin
        if (r_count < bus.lower) begin
          w_count_n = bus.lower;
        end else if (r_count > bus.upper) begin
          w_count_n = bus.upper;
        end else begin
          unique case (w_mode)
            MODE_WRAP: begin
              if (w_dir_eff) begin
                w_count_n = w_up_over ? bus.lower : w_stepped;
              end else begin
                w_count_n = w_dn_below ? bus.upper : w_stepped;
              end
              w_done_n = w_hit;
            end
            MODE_SAT, MODE_ONESHOT: begin
              if (w_hit) begin
                w_count_n = w_bound;
                w_done_n  = (r_count != w_bound);
                if (w_mode == MODE_ONESHOT) begin
                  w_run_n = 1'b0;
                end
              end else begin
                w_count_n = w_stepped;
              end
            end
            MODE_BOUNCE: begin
              if (w_hit) begin
                w_count_n = w_bound;
                w_done_n  = 1'b1;
                w_dir_n   = ~r_dir;
              end else begin
                w_count_n = w_stepped;
              end
            end
            default: begin
              w_count_n = r_count;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_done  <= 1'b0;
      r_dir   <= 1'b1;
      r_run   <= 1'b1;
    end else begin
      r_count <= w_count_n;
      r_done  <= w_done_n;
      r_dir   <= w_dir_n;
      r_run   <= w_run_n;
    end
  end

  assign bus.count_out = r_count;
  assign bus.done      = r_done;
  assign bus.dir_out   = r_dir;
  assign bus.running   = r_run;
  assign bus.cfg_err   = w_cfg_err;

endmodule

// File: tb/tb_ud_ld_counter_gen.sv
// Vector-table bench for ud_ld_counter_gen: each record is driven on the falling
// edge, its expectation queued, then popped and compared just after the rising edge.
module tb_ud_ld_counter_gen;

  localparam int unsigned W = 8;
  localparam int unsigned S = 4;

  typedef struct {
    logic         rst;
    logic         en;
    logic         ud;
    logic         ld;
    logic [W-1:0] lc;
    logic [S-1:0] st;
    logic [W-1:0] lo;
    logic [W-1:0] up;
    logic [1:0]   md;
    logic [W-1:0] e_cnt;
    logic         e_done;
    logic         e_dir;
    logic         e_run;
    logic         e_err;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] cnt;
    logic         done;
    logic         dir;
    logic         run;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ud_ld_counter_gen_if #(.WIDTH(W), .STEP_W(S)) bus ();

  ud_ld_counter_gen #(.WIDTH(W), .STEP_W(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic rst, input logic en, input logic ud, input logic ld,
                              input int lc, input int st, input int lo, input int up, input int md,
                              input int e_cnt, input logic e_done, input logic e_dir,
                              input logic e_run, input logic e_err);
    vec_t v;
    v.rst = rst; v.en = en; v.ud = ud; v.ld = ld;
    v.lc = W'(lc); v.st = S'(st); v.lo = W'(lo); v.up = W'(up); v.md = 2'(md);
    v.e_cnt = W'(e_cnt); v.e_done = e_done; v.e_dir = e_dir; v.e_run = e_run; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d want %0d", nm, idx, act, want);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    reset          = v.rst;
    bus.enable     = v.en;
    bus.updown     = v.ud;
    bus.load       = v.ld;
    bus.load_count = v.lc;
    bus.step       = v.st;
    bus.lower      = v.lo;
    bus.upper      = v.up;
    bus.mode       = v.md;
    e.idx = idx; e.cnt = v.e_cnt; e.done = v.e_done; e.dir = v.e_dir;
    e.run = v.e_run; e.err = v.e_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard vec %0d: got empty queue want entry", idx);
    end else begin
      g = exp_q.pop_front();
      chk("count_out", g.idx, int'(bus.count_out), int'(g.cnt));
      chk("done",      g.idx, int'(bus.done),      int'(g.done));
      chk("dir_out",   g.idx, int'(bus.dir_out),   int'(g.dir));
      chk("running",   g.idx, int'(bus.running),   int'(g.run));
      chk("cfg_err",   g.idx, int'(bus.cfg_err),   int'(g.err));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.updown = 1'b1; bus.load = 1'b0; bus.load_count = '0;
    bus.step = S'(1); bus.lower = '0; bus.upper = W'(255); bus.mode = 2'b00;

    // rst en ud ld lc st lo up md | cnt done dir run err
    add(1,0,1,0,  0,1, 0,255,0,   0,0,1,1,0);
    // wrap up 10..20 step 3
    add(0,0,1,1, 10,3,10, 20,0,  10,0,1,1,0);
    add(0,1,1,0,  0,3,10, 20,0,  13,0,1,1,0);
    add(0,1,1,0,  0,3,10, 20,0,  16,0,1,1,0);
    add(0,1,1,0,  0,3,10, 20,0,  19,0,1,1,0);
    add(0,1,1,0,  0,3,10, 20,0,  10,1,1,1,0);
    add(0,1,1,0,  0,3,10, 20,0,  13,0,1,1,0);
    // wrap down: past lower wraps to upper, exact lower pulses too
    add(0,0,0,1, 12,3,10, 20,0,  12,0,0,1,0);
    add(0,1,0,0,  0,3,10, 20,0,  20,1,0,1,0);
    add(0,1,0,0,  0,3,10, 20,0,  17,0,0,1,0);
    add(0,0,0,1, 13,3,10, 20,0,  13,0,0,1,0);
    add(0,1,0,0,  0,3,10, 20,0,  10,1,0,1,0);
    add(0,1,0,0,  0,3,10, 20,0,  20,1,0,1,0);
    // saturate down lower 2 step 4, then sustained hold without repeated pulse
    add(0,0,0,1,  9,4, 2, 20,1,   9,0,0,1,0);
    add(0,1,0,0,  0,4, 2, 20,1,   5,0,0,1,0);
    add(0,1,0,0,  0,4, 2, 20,1,   2,1,0,1,0);
    for (int i = 0; i < 5; i++) add(0,1,0,0, 0,4,2,20,1, 2,0,0,1,0);
    // enable low freezes mid-run
    add(0,0,0,1, 20,4, 2, 20,1,  20,0,0,1,0);
    add(0,1,0,0,  0,4, 2, 20,1,  16,0,0,1,0);
    add(0,0,0,0,  0,4, 2, 20,1,  16,0,0,1,0);
    add(0,0,0,0,  0,4, 2, 20,1,  16,0,0,1,0);
    add(0,1,0,0,  0,4, 2, 20,1,  12,0,0,1,0);
    // saturate up, then upper lowered below count
    add(0,0,1,1, 18,4, 0, 20,1,  18,0,1,1,0);
    add(0,1,1,0,  0,4, 0, 20,1,  20,1,1,1,0);
    add(0,1,1,0,  0,4, 0, 20,1,  20,0,1,1,0);
    add(0,1,1,0,  0,4, 0, 15,1,  15,0,1,1,0);
    add(0,1,1,0,  0,4, 0, 15,1,  15,0,1,1,0);
    // one-shot from reset
    add(1,0,1,0,  0,5, 0, 15,2,   0,0,1,1,0);
    add(0,1,1,0,  0,5, 0, 15,2,   5,0,1,1,0);
    add(0,1,1,0,  0,5, 0, 15,2,  10,0,1,1,0);
    add(0,1,1,0,  0,5, 0, 15,2,  15,1,1,0,0);
    for (int i = 0; i < 2; i++) add(0,1,1,0, 0,5,0,15,2, 15,0,1,0,0);
    add(0,1,1,1,  3,5, 0, 15,2,   3,0,1,1,0);
    add(0,1,1,0,  0,5, 0, 15,2,   8,0,1,1,0);
    add(0,1,1,0,  0,5, 0, 15,2,  13,0,1,1,0);
    add(0,1,1,0,  0,5, 0, 15,2,  15,1,1,0,0);
    // bounce 0..6 step 2; updown toggled and ignored
    add(1,0,1,0,  0,2, 0,  6,3,   0,0,1,1,0);
    add(0,1,0,0,  0,2, 0,  6,3,   2,0,1,1,0);
    add(0,1,1,0,  0,2, 0,  6,3,   4,0,1,1,0);
    add(0,1,0,0,  0,2, 0,  6,3,   6,1,0,1,0);
    add(0,1,1,0,  0,2, 0,  6,3,   4,0,0,1,0);
    add(0,1,0,0,  0,2, 0,  6,3,   2,0,0,1,0);
    add(0,1,1,0,  0,2, 0,  6,3,   0,1,1,1,0);
    add(0,1,0,0,  0,2, 0,  6,3,   2,0,1,1,0);
    // bounce: load sets direction, borrow past lower clamps to lower
    add(0,0,0,1,  3,2, 0,  6,3,   3,0,0,1,0);
    add(0,1,1,0,  0,2, 0,  6,3,   1,0,0,1,0);
    add(0,1,1,0,  0,2, 0,  6,3,   0,1,1,1,0);
    add(0,1,1,0,  0,2, 0,  6,3,   2,0,1,1,0);
    // bounce with lower == upper
    add(0,0,1,1,  5,2, 5,  5,3,   5,0,1,1,0);
    add(0,1,1,0,  0,2, 5,  5,3,   5,1,0,1,0);
    add(0,1,1,0,  0,2, 5,  5,3,   5,1,1,1,0);
    // load beats enable and clamps; next step wraps
    add(0,1,1,1,250,1, 0,200,0, 200,0,1,1,0);
    add(0,1,1,0,  0,1, 0,200,0,   0,1,1,1,0);
    // step 0 counts by one
    add(0,0,1,1, 50,0, 0,200,0,  50,0,1,1,0);
    add(0,1,1,0,  0,0, 0,200,0,  51,0,1,1,0);
    add(0,1,1,0,  0,0, 0,200,0,  52,0,1,1,0);
    // reset mid-count
    add(1,1,1,0,  0,0, 0,200,0,   0,0,1,1,0);
    add(0,1,1,0,  0,0, 0,200,0,   1,0,1,1,0);
    // reset beats a bad configuration; then bad config holds
    add(1,1,1,0,  0,1,30, 20,0,   0,0,1,1,1);
    add(0,1,1,0,  0,1,30, 20,0,   0,0,1,1,1);
    add(0,1,1,1, 15,1,30, 20,0,   0,0,1,1,1);
    // restored bounds: out-of-range count clamps without a pulse
    add(0,1,1,0,  0,1,10, 20,0,  10,0,1,1,0);
    add(0,1,1,0,  0,1,10, 20,0,  11,0,1,1,0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
